// File: rtl/bg_vram_fetch_arbiter.sv
// bg_vram_fetch_arbiter
//   Round-robin scheduler that shares the single background VRAM read port
//   among NUM_BG fetch engines. It grants one requester per cycle, issues a
//   registered VRAM read, and returns the read data tagged with the requester
//   id RD_LAT cycles after the strobe. When enable drops, it stops granting and
//   drains the reads already in flight before going idle.
// Ports
//   clk, rst_b        clock (posedge), asynchronous active-low reset
//   enable            background fetching enabled
//   line_start        scanline-start pulse, resets the round-robin pointer
//   cpu_hold          CPU owns VRAM this cycle, so no grant is issued
//   req, req_addr     per-requester request and address (slice i = requester i)
//   gnt               combinational one-hot grant
//   vram_re/addr      registered VRAM read strobe and address
//   vram_rdata        VRAM read data, valid RD_LAT cycles after vram_re
//   rsp_valid/id/data tagged response (rsp_data passes vram_rdata straight through)
//   busy              high while running or draining
module bg_vram_fetch_arbiter #(
  parameter int unsigned NUM_BG = 4,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2,
  localparam int unsigned ID_W  = $clog2(NUM_BG)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     enable,
  input  logic                     line_start,
  input  logic                     cpu_hold,
  input  logic [NUM_BG-1:0]        req,
  input  logic [NUM_BG*ADDR_W-1:0] req_addr,
  output logic [NUM_BG-1:0]        gnt,
  output logic                     vram_re,
  output logic [ADDR_W-1:0]        vram_addr,
  input  logic [DATA_W-1:0]        vram_rdata,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     win_id;
  logic                win_valid;
  logic [ADDR_W-1:0]   win_addr;
  logic [ID_W-1:0]     issue_id;
  logic [RD_LAT-1:0]   pipe_valid;
  logic [ID_W-1:0]     pipe_id [RD_LAT];
  logic                inflight_any;

  // Rotating priority search starting at ptr; the first requester found wins.
  always_comb begin
    cand      = '0;
    win_id    = '0;
    win_valid = 1'b0;
    gnt       = '0;
    win_addr  = '0;
    if (state == RUN && enable && !cpu_hold) begin
      for (int unsigned k = 0; k < NUM_BG; k++) begin
        cand = ID_W'((32'(ptr) + k) % NUM_BG);
        if (!win_valid && req[cand]) begin
          win_valid = 1'b1;
          win_id    = cand;
        end
      end
    end
    if (win_valid) begin
      gnt[win_id] = 1'b1;
      win_addr    = req_addr[win_id*ADDR_W +: ADDR_W];
    end
  end

  // A read is in flight from the strobe cycle until its response stage has
  // been shown, which covers the strobe plus every tag-pipeline stage.
  assign inflight_any = vram_re | (|pipe_valid);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = inflight_any ? DRAIN : IDLE;
      DRAIN:   if (!inflight_any) state_next = enable ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      ptr       <= '0;
      vram_re   <= 1'b0;
      vram_addr <= '0;
      issue_id  <= '0;
    end else begin
      state   <= state_next;
      vram_re <= win_valid;
      if (win_valid) begin
        vram_addr <= win_addr;
        issue_id  <= win_id;
      end
      // line_start wins over the post-grant pointer advance.
      if (line_start) begin
        ptr <= '0;
      end else if (win_valid) begin
        ptr <= win_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_id[i] <= '0;
    end else begin
      pipe_valid[0] <= vram_re;
      pipe_id[0]    <= issue_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[RD_LAT-1];
  assign rsp_id    = pipe_id[RD_LAT-1];
  assign rsp_data  = vram_rdata;
  assign busy      = (state != IDLE);

endmodule
